// File: rtl/ship_placer.sv
// Ship placement stage: cursor/rotate/place with serial overlap check.
// Holds the occupancy board for the shot logic once all ships are placed.
module ship_placer #(
  parameter int ROWS      = 5,
  parameter int COLS      = 5,
  parameter int MAX_SHIPS = 5,
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [2:0]           n_barcos,
  input  logic                 up,
  input  logic                 down,
  input  logic                 left,
  input  logic                 right,
  input  logic                 rot,
  input  logic                 place,
  output logic [RW-1:0]        cur_row,
  output logic [CW-1:0]        cur_col,
  output logic                 orient,
  output logic [2:0]           ship_idx,
  output logic [ROWS*COLS-1:0] board,
  output logic                 busy,
  output logic                 err,
  output logic                 RBarcos
);
  localparam int NC = ROWS * COLS;
  localparam int IW = $clog2(NC);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_EDIT   = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]    r_state;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          r_orient;
  logic [2:0]    r_idx;
  logic [NC-1:0] r_board;
  logic          r_err;
  logic [2:0]    r_nb;
  logic [2:0]    r_k;

  logic [3:0]    w_len;
  logic [2:0]    w_nb;
  logic          w_fits;
  logic          w_occ;
  logic          w_last;
  logic [NC-1:0] w_mask;

  assign w_len = {1'b0, r_idx} + 4'd1;
  assign w_last = ({1'b0, r_k} == (w_len - 4'd1));

  always_comb begin
    w_nb = n_barcos;
    if (n_barcos == 3'd0) w_nb = 3'd1;
    else if (int'(n_barcos) > MAX_SHIPS) w_nb = 3'(MAX_SHIPS);
  end

  always_comb begin
    if (r_orient) w_fits = (int'(r_row) + int'(w_len)) <= ROWS;
    else          w_fits = (int'(r_col) + int'(w_len)) <= COLS;
  end

  // Cell k of the candidate ship, probed one per cycle in CHECK
  always_comb begin
    int ri;
    int ci;
    ri = int'(r_row) + (r_orient ? int'(r_k) : 0);
    ci = int'(r_col) + (r_orient ? 0 : int'(r_k));
    w_occ = 1'b0;
    if (ri * COLS + ci < NC) w_occ = r_board[IW'(ri * COLS + ci)];
  end

  always_comb begin
    int ci;
    w_mask = '0;
    for (int k = 0; k < MAX_SHIPS; k++) begin
      if (r_orient) ci = (int'(r_row) + k) * COLS + int'(r_col);
      else          ci = int'(r_row) * COLS + int'(r_col) + k;
      if (k < int'(w_len) && ci < NC) w_mask[IW'(ci)] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_row    <= '0;
      r_col    <= '0;
      r_orient <= 1'b0;
      r_idx    <= '0;
      r_board  <= '0;
      r_err    <= 1'b0;
      r_nb     <= 3'd1;
      r_k      <= '0;
    end else begin
      r_err <= 1'b0;
      if (!en) begin
        r_state <= S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_board  <= '0;
            r_idx    <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_orient <= 1'b0;
            r_nb     <= w_nb;
            r_state  <= S_EDIT;
          end
          S_EDIT: begin
            if (place) begin
              if (w_fits) begin
                r_k     <= '0;
                r_state <= S_CHECK;
              end else begin
                r_err <= 1'b1;
              end
            end else begin
              if (rot) r_orient <= ~r_orient;
              if (up && !down && r_row != '0)
                r_row <= r_row - 1'b1;
              else if (down && !up && int'(r_row) < ROWS - 1)
                r_row <= r_row + 1'b1;
              if (left && !right && r_col != '0)
                r_col <= r_col - 1'b1;
              else if (right && !left && int'(r_col) < COLS - 1)
                r_col <= r_col + 1'b1;
            end
          end
          S_CHECK: begin
            if (w_occ) begin
              r_err   <= 1'b1;
              r_state <= S_EDIT;
            end else if (w_last) begin
              r_state <= S_COMMIT;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
          S_COMMIT: begin
            r_board <= r_board | w_mask;
            r_idx   <= r_idx + 1'b1;
            if (w_len == {1'b0, r_nb}) r_state <= S_DONE;
            else                       r_state <= S_EDIT;
          end
          S_DONE: r_state <= S_DONE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign cur_row  = r_row;
  assign cur_col  = r_col;
  assign orient   = r_orient;
  assign ship_idx = r_idx;
  assign board    = r_board;
  assign err      = r_err;
  assign busy     = (r_state == S_CHECK) || (r_state == S_COMMIT);
  assign RBarcos  = (r_state == S_DONE);
endmodule
